conv_stream_param: RTL and testbench

CONV_STREAM_PARAM -- requirements
Module: conv_stream_param

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_mem.sv | 22 ++
 rtl/conv_sat_mac.sv | 56 +++++
 rtl/conv_stream_param.sv | 148 ++++++++++++++
 tb/tb_conv_stream_param.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution block.
// Holds the FSM state type and the per-frame output count.
package conv_pkg;

  typedef enum logic [2:0] {
    LOAD_F,
    LOAD_X,
    COMPUTE,
    OUTPUT,
    IDLE
  } state_t;

  function automatic int y_len(
    input int x_len,
    input int f_len,
    input int stride
  );
    return (x_len - f_len) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mem.sv
// Single-port synchronous RAM, one-cycle read latency.
// Read-first: a write returns the old word on rdata.
module conv_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_sat_mac.sv
// Saturating multiply-accumulate: registered product,
// accumulator clamped to the WIDTH-bit range on every add.
module conv_sat_mac #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH:0]   acc
);

  localparam logic [WIDTH-1:0] MAXV =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]            top_bits;
  logic [WIDTH-1:0]          prod_sat;
  logic [WIDTH-1:0]          prod_q;
  logic [WIDTH:0]            sum;
  logic [WIDTH:0]            sum_sat;

  assign prod_full = a * b;
  assign top_bits  = prod_full[2*WIDTH-1:WIDTH-1];

  always_comb begin
    prod_sat = prod_full[WIDTH-1:0];
    if (!(&top_bits) && (|top_bits))
      prod_sat = prod_full[2*WIDTH-1] ? MINV : MAXV;
  end

  // acc never leaves the WIDTH range, so WIDTH+1 bits hold the sum
  assign sum = acc + {prod_q[WIDTH-1], prod_q};

  always_comb begin
    sum_sat = sum;
    if (sum[WIDTH] != sum[WIDTH-1])
      sum_sat = sum[WIDTH] ? {1'b1, MINV} : {1'b0, MAXV};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc    <= '0;
    end else begin
      prod_q <= prod_sat;
      if (clear)   acc <= '0;
      else if (en) acc <= sum_sat;
    end
  end

endmodule

// File: rtl/conv_stream_param.sv
// Streaming 1-D convolution: load filter, load frame,
// then emit one saturated (optionally rectified) sum per step.
module conv_stream_param
  import conv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int X_LEN  = 16,
  parameter int F_LEN  = 6,
  parameter int STRIDE = 1,
  parameter int RELU   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] f_data,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int Y_LEN = y_len(X_LEN, F_LEN, STRIDE);
  localparam int CW    = $clog2(X_LEN + 4);
  localparam int XAW   = (X_LEN > 1) ? $clog2(X_LEN) : 1;
  localparam int FAW   = (F_LEN > 1) ? $clog2(F_LEN) : 1;

  localparam logic [CW-1:0] F_LAST = CW'(F_LEN - 1);
  localparam logic [CW-1:0] X_LAST = CW'(X_LEN - 1);
  localparam logic [CW-1:0] K_LAST = CW'(Y_LEN - 1);
  localparam logic [CW-1:0] F_CNT  = CW'(F_LEN);
  localparam logic [CW-1:0] ACC_LO = CW'(2);
  localparam logic [CW-1:0] ACC_HI = CW'(F_LEN + 1);
  localparam logic [CW-1:0] FIN    = CW'(F_LEN + 2);
  localparam logic [CW-1:0] STEP   = CW'(STRIDE);

  state_t state, state_nxt;

  logic [CW-1:0]         wcnt, cnt, kcnt, xb, rd_j;
  logic                  f_fire, x_fire, y_fire;
  logic                  mac_en, mac_clr, f_load;
  logic [XAW-1:0]        x_addr;
  logic [FAW-1:0]        f_addr;
  logic [WIDTH-1:0]      x_q, f_q, y_q;
  logic signed [WIDTH:0] acc;

  always_comb begin
    state_nxt = state;
    f_ready   = 1'b0;
    x_ready   = 1'b0;
    y_valid   = 1'b0;
    unique case (state)
      LOAD_F: begin
        f_ready = 1'b1;
        if (f_valid && wcnt == F_LAST) state_nxt = LOAD_X;
      end
      LOAD_X: begin
        x_ready = 1'b1;
        if (x_valid && wcnt == X_LAST) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (cnt == FIN) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        y_valid = 1'b1;
        if (y_ready)
          state_nxt = (kcnt == K_LAST) ? IDLE : COMPUTE;
      end
      IDLE: begin
        f_ready = 1'b1;
        x_ready = !f_valid;
        if (f_valid)
          state_nxt = (F_LEN == 1) ? LOAD_X : LOAD_F;
        else if (x_valid)
          state_nxt = (X_LEN == 1) ? COMPUTE : LOAD_X;
      end
      default: state_nxt = LOAD_F;
    endcase
  end

  assign f_fire  = f_valid && f_ready;
  assign x_fire  = x_valid && x_ready;
  assign y_fire  = y_valid && y_ready;
  assign mac_clr = state != COMPUTE;
  assign mac_en  = state == COMPUTE &&
                   cnt >= ACC_LO && cnt <= ACC_HI;
  assign f_load  = state == LOAD_F || state == IDLE;

  // tail cycles of a step read tap 0 so addresses stay in range
  assign rd_j   = (cnt < F_CNT) ? cnt : '0;
  assign x_addr = (state == COMPUTE) ?
                  XAW'(xb + rd_j) : XAW'(wcnt);
  assign f_addr = f_load ? FAW'(wcnt) : FAW'(rd_j);
  assign y_data = y_valid ? y_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_F;
      wcnt  <= '0;
      cnt   <= '0;
      kcnt  <= '0;
      xb    <= '0;
      y_q   <= '0;
    end else begin
      state <= state_nxt;
      if ((f_fire && wcnt == F_LAST) ||
          (x_fire && wcnt == X_LAST))
        wcnt <= '0;
      else if (f_fire || x_fire)
        wcnt <= wcnt + 1'b1;
      cnt <= (state == COMPUTE) ? cnt + 1'b1 : '0;
      if (state == LOAD_X || state == IDLE) begin
        kcnt <= '0;
        xb   <= '0;
      end else if (y_fire) begin
        kcnt <= kcnt + 1'b1;
        xb   <= xb + STEP;
      end
      if (state == COMPUTE && cnt == FIN) begin
        if (RELU != 0 && acc[WIDTH]) y_q <= '0;
        else                         y_q <= acc[WIDTH-1:0];
      end
    end
  end

  conv_mem #(
    .WIDTH(WIDTH), .DEPTH(X_LEN), .AW(XAW)
  ) u_xmem (
    .clk(clk), .we(x_fire), .addr(x_addr),
    .wdata(x_data), .rdata(x_q)
  );

  conv_mem #(
    .WIDTH(WIDTH), .DEPTH(F_LEN), .AW(FAW)
  ) u_fmem (
    .clk(clk), .we(f_fire), .addr(f_addr),
    .wdata(f_data), .rdata(f_q)
  );

  conv_sat_mac #(.WIDTH(WIDTH)) u_mac (
    .clk(clk), .reset(reset),
    .en(mac_en), .clear(mac_clr),
    .a(x_q), .b(f_q), .acc(acc)
  );

endmodule

// File: tb/tb_conv_stream_param.sv
// Bench for conv_stream_param: three parameter sets on a shared
// stimulus bus, checked against a reference convolution model.
module tb_conv_stream_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] fd = '0, xd = '0;
  logic fv = 1'b0, xv = 1'b0, yr = 1'b1;
  int sel = 0;
  int stall = 0;

  logic        fr[3], xr[3], yv[3];
  logic [15:0] yd[3];
  logic fr_s, xr_s, yv_s;
  logic signed [15:0] yd_s;

  assign fr_s = fr[sel];
  assign xr_s = xr[sel];
  assign yv_s = yv[sel];
  assign yd_s = yd[sel];

  int xl[3] = '{16, 8, 16};
  int fl[3] = '{6, 3, 6};
  int st[3] = '{1, 2, 1};
  int rl[3] = '{1, 1, 0};

  conv_stream_param u0 (
    .clk(clk), .reset(reset),
    .f_data(fd), .f_valid(fv && sel == 0), .f_ready(fr[0]),
    .x_data(xd), .x_valid(xv && sel == 0), .x_ready(xr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr && sel == 0)
  );

  conv_stream_param #(.X_LEN(8), .F_LEN(3), .STRIDE(2)) u1 (
    .clk(clk), .reset(reset),
    .f_data(fd), .f_valid(fv && sel == 1), .f_ready(fr[1]),
    .x_data(xd), .x_valid(xv && sel == 1), .x_ready(xr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr && sel == 1)
  );

  conv_stream_param #(.RELU(0)) u2 (
    .clk(clk), .reset(reset),
    .f_data(fd), .f_valid(fv && sel == 2), .f_ready(fr[2]),
    .x_data(xd), .x_valid(xv && sel == 2), .x_ready(xr[2]),
    .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr && sel == 2)
  );

  int checks = 0;
  int errors = 0;
  int fm[16];
  int xm[16];
  int exp_q[$];

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int ylen();
    return (xl[sel] - fl[sel]) / st[sel] + 1;
  endfunction

  // reference: direct convolution with saturation and optional ReLU
  task automatic model();
    int acc;
    for (int k = 0; k < ylen(); k++) begin
      acc = 0;
      for (int j = 0; j < fl[sel]; j++)
        acc = sat16(acc + sat16(xm[k*st[sel]+j] * fm[j]));
      if (rl[sel] != 0 && acc < 0) acc = 0;
      exp_q.push_back(acc);
    end
  endtask

  task automatic wait_rdy(input bit is_x);
    int t = 0;
    @(negedge clk);
    while (!(is_x ? xr_s : fr_s) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk(is_x ? "x_ready_timeout" : "f_ready_timeout",
                      0, 1);
  endtask

  task automatic push_f(input int d);
    fd = 16'(d);
    fv = 1'b1;
    wait_rdy(1'b0);
    @(posedge clk); #1;
    fv = 1'b0;
  endtask

  task automatic push_x(input int d);
    xd = 16'(d);
    xv = 1'b1;
    wait_rdy(1'b1);
    @(posedge clk); #1;
    xv = 1'b0;
  endtask

  task automatic load_f();
    for (int i = 0; i < fl[sel]; i++) push_f(fm[i]);
  endtask

  task automatic load_x();
    for (int i = 0; i < xl[sel]; i++) push_x(xm[i]);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(exp_q.size() == 0 && fr_s && xr_s) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("frame_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall > 0 && yv_s) begin
        yr = 1'b0;
        stall--;
      end else begin
        yr = 1'b1;
      end
    end
  end

  int  xn = 0, yn = 0, lat = 0;
  bit  lat_on = 1'b0, pv = 1'b0, phs = 1'b0;
  logic signed [15:0] py = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        xn = 0; yn = 0; lat_on = 1'b0; pv = 1'b0; phs = 1'b0;
      end else begin
        if (lat_on) begin
          lat++;
          if (yv_s) begin
            chk("y_valid_latency", lat, fl[sel] + 3);
            lat_on = 1'b0;
          end else if (lat > 60) begin
            chk("y_valid_latency", lat, fl[sel] + 3);
            lat_on = 1'b0;
          end
        end
        if (yv_s) begin
          if (pv && !phs) chk("y_stable", yd_s, py);
          if (yr) begin
            if (exp_q.size() == 0) chk("y_extra", 1, 0);
            else chk("y_data", yd_s, exp_q.pop_front());
            yn++;
            if (yn < ylen()) begin
              lat_on = 1'b1;
              lat = -1;
            end else begin
              yn = 0;
            end
          end
        end else begin
          chk("y_data_idle_zero", yd_s, 0);
        end
        pv = yv_s;
        py = yd_s;
        phs = yv_s && yr;
        if (xv && xr_s) begin
          xn++;
          if (xn == xl[sel]) begin
            xn = 0;
            lat_on = 1'b1;
            lat = -1;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_f_ready", fr_s, 1);
    chk("rst_x_ready", xr_s, 0);
    chk("rst_y_valid", yv_s, 0);
    chk("rst_y_data", yd_s, 0);
    @(posedge clk); #1;

    // default frame with backpressure on the first output
    for (int i = 0; i < 16; i++) begin fm[i] = 1; xm[i] = i; end
    stall = 5;
    load_f();
    model();
    chk("pin_default_count", exp_q.size(), 11);
    chk("pin_default_y0", exp_q[0], 15);
    chk("pin_default_y1", exp_q[1], 21);
    chk("pin_default_y10", exp_q[10], 75);
    load_x();
    wait_done();

    // x-only frame from IDLE reuses the stored filter
    for (int i = 0; i < 16; i++) xm[i] = 15 - i;
    model();
    chk("pin_reuse_y0", exp_q[0], 75);
    chk("pin_reuse_y10", exp_q[10], 15);
    load_x();
    wait_done();

    // f and x offered together in IDLE: only f is taken
    for (int i = 0; i < 6; i++) fm[i] = 0;
    fm[0] = 2; fm[5] = -1;
    for (int i = 0; i < 16; i++) xm[i] = i;
    fd = 16'(fm[0]); fv = 1'b1;
    xd = 16'd99;     xv = 1'b1;
    @(negedge clk);
    chk("idle_both_x_ready", xr_s, 0);
    chk("idle_both_f_ready", fr_s, 1);
    @(posedge clk); #1;
    fv = 1'b0; xv = 1'b0;
    for (int i = 1; i < 6; i++) push_f(fm[i]);
    model();
    chk("pin_fwin_y0", exp_q[0], 0);
    chk("pin_fwin_y10", exp_q[10], 5);
    load_x();
    wait_done();

    // product and accumulator saturation
    for (int i = 0; i < 16; i++) begin
      fm[i] = 32767; xm[i] = 32767;
    end
    load_f();
    model();
    chk("pin_sat_y0", exp_q[0], 32767);
    load_x();
    wait_done();

    // ReLU clamps a negative sum
    for (int i = 0; i < 16; i++) begin fm[i] = -1; xm[i] = 5; end
    load_f();
    model();
    chk("pin_relu_y0", exp_q[0], 0);
    load_x();
    wait_done();

    // reset in the middle of COMPUTE
    for (int i = 0; i < 16; i++) begin
      fm[i] = i + 1; xm[i] = 3 * i - 5;
    end
    load_f();
    load_x();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_f_ready", fr_s, 1);
    chk("midrst_x_ready", xr_s, 0);
    chk("midrst_y_valid", yv_s, 0);
    chk("midrst_y_data", yd_s, 0);
    @(posedge clk); #1;
    load_f();
    model();
    chk("pin_midrst_y0", exp_q[0], 105);
    load_x();
    wait_done();

    // pass-through instance
    sel = 2;
    for (int i = 0; i < 16; i++) begin fm[i] = -1; xm[i] = 5; end
    load_f();
    model();
    chk("pin_norelu_y0", exp_q[0], -30);
    load_x();
    wait_done();
    for (int i = 0; i < 16; i++) begin
      fm[i] = -32768; xm[i] = 1;
    end
    load_f();
    model();
    chk("pin_negsat_y0", exp_q[0], -32768);
    load_x();
    wait_done();

    // stride-2 instance
    sel = 1;
    fm[0] = 1; fm[1] = 0; fm[2] = 0;
    for (int i = 0; i < 8; i++) xm[i] = 10 + i;
    load_f();
    model();
    chk("pin_stride_count", exp_q.size(), 3);
    chk("pin_stride_y0", exp_q[0], 10);
    chk("pin_stride_y1", exp_q[1], 12);
    chk("pin_stride_y2", exp_q[2], 14);
    load_x();
    wait_done();

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
